// File: rtl/stopwatch_ctrl_if.sv
// Front-panel / counter handshake bundle for stopwatch_ctrl.
// STOPWATCH_CTRL_LAP_HOLD_EN adds the lap button and lap_hold output.
interface stopwatch_ctrl_if;
  logic       btn_pause;
  logic       btn_clr;
  logic       sw_adj;
  logic       sw_sel;
  logic       counter_tick;
  logic       adj_tick;
  logic       blink_tick;
  logic       cnt_en;
  logic       cnt_clr;
  logic       inc_sec;
  logic       inc_min;
  logic       blank_sec;
  logic       blank_min;
  logic [1:0] state;
`ifdef STOPWATCH_CTRL_LAP_HOLD_EN
  logic       btn_lap;
  logic       lap_hold;
`endif

  modport master (
    output btn_pause, btn_clr, sw_adj, sw_sel, counter_tick, adj_tick, blink_tick,
`ifdef STOPWATCH_CTRL_LAP_HOLD_EN
    output btn_lap,
    input  lap_hold,
`endif
    input  cnt_en, cnt_clr, inc_sec, inc_min, blank_sec, blank_min, state
  );

  modport slave (
    input  btn_pause, btn_clr, sw_adj, sw_sel, counter_tick, adj_tick, blink_tick,
`ifdef STOPWATCH_CTRL_LAP_HOLD_EN
    input  btn_lap,
    output lap_hold,
`endif
    output cnt_en, cnt_clr, inc_sec, inc_min, blank_sec, blank_min, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/adjust mode controller driving the stopwatch counter strobes and display blanking.
// Optional lap-hold feature: STOPWATCH_CTRL_LAP_HOLD_EN.
//
// state   | meaning
// CLEARED | counter zeroed, idle
// RUN     | counter_tick produces cnt_en
// PAUSED  | counting halted, value held
// ADJUST  | adj_tick steps the selected field, selected field blinks
module stopwatch_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  stopwatch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    CLEARED = 2'b00,
    RUN     = 2'b01,
    PAUSED  = 2'b10,
    ADJUST  = 2'b11
  } state_t;

`ifdef STOPWATCH_CTRL_LAP_HOLD_EN
  localparam int NBTN = 3;
`else
  localparam int NBTN = 2;
`endif
  localparam int NIN = NBTN + 2;
  localparam int AW  = $clog2(SYNC_STAGES + 2);

  logic [NIN-1:0]                  raw;
  logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
  logic [NIN-1:0]                  syn;
  logic [NBTN-1:0]                 btn_d;
  logic [NBTN-1:0]                 rise;
  logic [AW-1:0]                   arm_cnt;
  logic                            armed;
  logic pause_rise, clr_rise, adj_s, sel_s;
  logic enter_adj;
  logic phase;
  state_t state_q, state_n;

`ifdef STOPWATCH_CTRL_LAP_HOLD_EN
  logic lap_rise;
  assign raw = {bus.sw_sel, bus.sw_adj, bus.btn_lap, bus.btn_clr, bus.btn_pause};
`else
  assign raw = {bus.sw_sel, bus.sw_adj, bus.btn_clr, bus.btn_pause};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      btn_d  <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      btn_d <= syn[NBTN-1:0];
    end
  end

  // Edges are ignored until the sync chain and edge flop hold real samples,
  // so a button already held through reset does not register as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                arm_cnt <= AW'(SYNC_STAGES + 1);
    else if (arm_cnt != '0) arm_cnt <= arm_cnt - 1'b1;
  end

  assign armed      = (arm_cnt == '0);
  assign syn        = sync_q[SYNC_STAGES-1];
  assign rise       = syn[NBTN-1:0] & ~btn_d & {NBTN{armed}};
  assign pause_rise = rise[0];
  assign clr_rise   = rise[1];
  assign adj_s      = syn[NBTN];
  assign sel_s      = syn[NBTN+1];
`ifdef STOPWATCH_CTRL_LAP_HOLD_EN
  assign lap_rise   = rise[2];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CLEARED;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    enter_adj = 1'b0;
    if (adj_s && state_q != ADJUST) begin
      state_n   = ADJUST;
      enter_adj = 1'b1;
    end else if (clr_rise) begin
      state_n = adj_s ? ADJUST : CLEARED;
    end else if (state_q == ADJUST && !adj_s) begin
      state_n = PAUSED;
    end else if (pause_rise) begin
      case (state_q)
        CLEARED: state_n = RUN;
        RUN:     state_n = PAUSED;
        PAUSED:  state_n = RUN;
        default: state_n = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cnt_en    <= 1'b0;
      bus.cnt_clr   <= 1'b0;
      bus.inc_sec   <= 1'b0;
      bus.inc_min   <= 1'b0;
      bus.blank_sec <= 1'b0;
      bus.blank_min <= 1'b0;
      phase         <= 1'b0;
    end else begin
      bus.cnt_en    <= bus.counter_tick & (state_q == RUN) & ~clr_rise;
      bus.cnt_clr   <= clr_rise;
      bus.inc_sec   <= bus.adj_tick & (state_q == ADJUST) & ~sel_s & ~clr_rise;
      bus.inc_min   <= bus.adj_tick & (state_q == ADJUST) & sel_s & ~clr_rise;
      bus.blank_sec <= (state_q == ADJUST) & phase & ~sel_s;
      bus.blank_min <= (state_q == ADJUST) & phase & sel_s;
      if (enter_adj || state_q != ADJUST) phase <= 1'b0;
      else                                phase <= phase ^ bus.blink_tick;
    end
  end

`ifdef STOPWATCH_CTRL_LAP_HOLD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    bus.lap_hold <= 1'b0;
    else if (enter_adj || clr_rise)             bus.lap_hold <= 1'b0;
    else if (lap_rise && state_q == RUN)        bus.lap_hold <= ~bus.lap_hold;
    else if (lap_rise && state_q == PAUSED)     bus.lap_hold <= 1'b0;
  end
`endif

  assign bus.state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl (SYNC_STAGES=2, so a press acts 3 edges after the level rises).
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stopwatch_ctrl_if bus();
  stopwatch_ctrl #(.SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_cmp = 0;
  int n_bad = 0;
  int c_en, c_clr, c_isec, c_imin, c_bsec, c_bmin;

  always @(negedge clk) if (!rst) begin
    if (bus.cnt_en)    c_en++;
    if (bus.cnt_clr)   c_clr++;
    if (bus.inc_sec)   c_isec++;
    if (bus.inc_min)   c_imin++;
    if (bus.blank_sec) c_bsec++;
    if (bus.blank_min) c_bmin++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic zero_counts();
    c_en = 0; c_clr = 0; c_isec = 0; c_imin = 0; c_bsec = 0; c_bmin = 0;
  endtask

  task automatic test_reset();
    step(2);
    n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL reset_state got=%b exp=00", bus.state); end
    n_cmp++; if ({bus.cnt_en, bus.cnt_clr, bus.inc_sec, bus.inc_min, bus.blank_sec, bus.blank_min} !== 6'b0) begin
      n_bad++; $display("FAIL reset_outputs got=%b exp=000000",
        {bus.cnt_en, bus.cnt_clr, bus.inc_sec, bus.inc_min, bus.blank_sec, bus.blank_min}); end
    rst = 1'b0;
    step(6);
    n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL held_pause_no_edge got=%b exp=00", bus.state); end
    bus.btn_pause = 1'b0; step(3);
    bus.btn_pause = 1'b1; step(3);
    n_cmp++; if (bus.state !== 2'b01) begin n_bad++; $display("FAIL repress_run got=%b exp=01", bus.state); end
    bus.btn_pause = 1'b0; step(3);
    bus.btn_clr = 1'b1; step(3);
    bus.btn_clr = 1'b0; step(3);
    n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL clr_to_cleared got=%b exp=00", bus.state); end
  endtask

  task automatic test_run_count();
    zero_counts();
    bus.btn_pause = 1'b1; step(3);
    n_cmp++; if (bus.state !== 2'b01) begin n_bad++; $display("FAIL run_entry got=%b exp=01", bus.state); end
    bus.btn_pause = 1'b0; step(2);
    for (int i = 0; i < 3; i++) begin
      bus.counter_tick = 1'b1; step(1); bus.counter_tick = 1'b0;
      n_cmp++; if (bus.cnt_en !== 1'b1) begin n_bad++; $display("FAIL cnt_en_tick_plus1 idx=%0d got=%b exp=1", i, bus.cnt_en); end
      step(1);
      n_cmp++; if (bus.cnt_en !== 1'b0) begin n_bad++; $display("FAIL cnt_en_width idx=%0d got=%b exp=0", i, bus.cnt_en); end
      step(1);
    end
    bus.btn_pause = 1'b1; step(3);
    n_cmp++; if (bus.state !== 2'b10) begin n_bad++; $display("FAIL run_to_paused got=%b exp=10", bus.state); end
    bus.btn_pause = 1'b0; step(2);
    bus.counter_tick = 1'b1; step(1); bus.counter_tick = 1'b0;
    n_cmp++; if (bus.cnt_en !== 1'b0) begin n_bad++; $display("FAIL paused_no_cnt_en got=%b exp=0", bus.cnt_en); end
    step(1);
    n_cmp++; if (c_en !== 3) begin n_bad++; $display("FAIL cnt_en_total got=%0d exp=3", c_en); end
  endtask

  task automatic test_clr_pause_same();
    bus.btn_pause = 1'b1; step(3);
    n_cmp++; if (bus.state !== 2'b01) begin n_bad++; $display("FAIL paused_to_run got=%b exp=01", bus.state); end
    bus.btn_pause = 1'b0; step(3);
    zero_counts();
    bus.btn_clr = 1'b1; bus.btn_pause = 1'b1;
    step(2);
    bus.counter_tick = 1'b1; step(1); bus.counter_tick = 1'b0;
    n_cmp++; if (bus.cnt_clr !== 1'b1) begin n_bad++; $display("FAIL same_cycle_cnt_clr got=%b exp=1", bus.cnt_clr); end
    n_cmp++; if (bus.cnt_en !== 1'b0) begin n_bad++; $display("FAIL clr_suppresses_cnt_en got=%b exp=0", bus.cnt_en); end
    n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL same_cycle_state got=%b exp=00", bus.state); end
    step(1);
    n_cmp++; if (bus.cnt_clr !== 1'b0) begin n_bad++; $display("FAIL cnt_clr_width got=%b exp=0", bus.cnt_clr); end
    step(4);
    bus.btn_clr = 1'b0; bus.btn_pause = 1'b0; step(3);
    n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL pause_discarded got=%b exp=00", bus.state); end
    n_cmp++; if (c_clr !== 1) begin n_bad++; $display("FAIL cnt_clr_total got=%0d exp=1", c_clr); end
  endtask

  task automatic test_adjust();
    zero_counts();
    bus.sw_sel = 1'b1; bus.sw_adj = 1'b1; step(3);
    n_cmp++; if (bus.state !== 2'b11) begin n_bad++; $display("FAIL adjust_entry got=%b exp=11", bus.state); end
    for (int i = 0; i < 4; i++) begin
      bus.adj_tick = 1'b1; step(1); bus.adj_tick = 1'b0;
      n_cmp++; if ({bus.inc_min, bus.inc_sec} !== 2'b10) begin n_bad++;
        $display("FAIL inc_min_step idx=%0d got=%b exp=10", i, {bus.inc_min, bus.inc_sec}); end
      step(1);
    end
    bus.blink_tick = 1'b1; step(1); bus.blink_tick = 1'b0; step(1);
    n_cmp++; if ({bus.blank_min, bus.blank_sec} !== 2'b10) begin n_bad++;
      $display("FAIL blank_min_on got=%b exp=10", {bus.blank_min, bus.blank_sec}); end
    bus.blink_tick = 1'b1; step(1); bus.blink_tick = 1'b0; step(1);
    n_cmp++; if ({bus.blank_min, bus.blank_sec} !== 2'b00) begin n_bad++;
      $display("FAIL blank_min_off got=%b exp=00", {bus.blank_min, bus.blank_sec}); end
    n_cmp++; if (c_imin !== 4) begin n_bad++; $display("FAIL inc_min_total got=%0d exp=4", c_imin); end
    n_cmp++; if (c_isec !== 0) begin n_bad++; $display("FAIL inc_sec_total got=%0d exp=0", c_isec); end
    n_cmp++; if (c_bmin !== 2) begin n_bad++; $display("FAIL blank_min_cycles got=%0d exp=2", c_bmin); end
    n_cmp++; if (c_bsec !== 0) begin n_bad++; $display("FAIL blank_sec_cycles got=%0d exp=0", c_bsec); end
    bus.sw_adj = 1'b0; step(3);
    n_cmp++; if (bus.state !== 2'b10) begin n_bad++; $display("FAIL adjust_exit got=%b exp=10", bus.state); end
    bus.sw_sel = 1'b0;
  endtask

  task automatic test_adj_clr();
    bus.sw_adj = 1'b1; step(3);
    n_cmp++; if (bus.state !== 2'b11) begin n_bad++; $display("FAIL adjust_from_paused got=%b exp=11", bus.state); end
    bus.adj_tick = 1'b1; step(1); bus.adj_tick = 1'b0;
    n_cmp++; if ({bus.inc_min, bus.inc_sec} !== 2'b01) begin n_bad++;
      $display("FAIL inc_sec_step got=%b exp=01", {bus.inc_min, bus.inc_sec}); end
    step(1);
    zero_counts();
    bus.btn_clr = 1'b1; step(3);
    n_cmp++; if (bus.cnt_clr !== 1'b1) begin n_bad++; $display("FAIL adj_cnt_clr got=%b exp=1", bus.cnt_clr); end
    n_cmp++; if (bus.state !== 2'b11) begin n_bad++; $display("FAIL adj_clr_state got=%b exp=11", bus.state); end
    step(1);
    bus.btn_clr = 1'b0; step(3);
    n_cmp++; if (c_clr !== 1) begin n_bad++; $display("FAIL adj_cnt_clr_total got=%0d exp=1", c_clr); end
    bus.sw_adj = 1'b0; step(3);
    n_cmp++; if (bus.state !== 2'b10) begin n_bad++; $display("FAIL adj_clr_exit got=%b exp=10", bus.state); end
  endtask

  task automatic test_reset_mid();
    bus.btn_pause = 1'b1; step(3);
    n_cmp++; if (bus.state !== 2'b01) begin n_bad++; $display("FAIL mid_run_entry got=%b exp=01", bus.state); end
    bus.btn_pause = 1'b0; step(2);
    bus.counter_tick = 1'b1; step(1);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.state, bus.cnt_en} !== 3'b000) begin n_bad++;
      $display("FAIL async_reset got=%b exp=000", {bus.state, bus.cnt_en}); end
    @(negedge clk);
    rst = 1'b0;
    step(1);
    bus.counter_tick = 1'b0;
    step(1);
    n_cmp++; if ({bus.state, bus.cnt_en, bus.cnt_clr} !== 4'b0000) begin n_bad++;
      $display("FAIL release_no_strobe got=%b exp=0000", {bus.state, bus.cnt_en, bus.cnt_clr}); end
    step(3);
  endtask

`ifdef STOPWATCH_CTRL_LAP_HOLD_EN
  task automatic test_lap();
    bus.btn_pause = 1'b1; step(3); bus.btn_pause = 1'b0; step(2);
    n_cmp++; if (bus.state !== 2'b01) begin n_bad++; $display("FAIL lap_run_entry got=%b exp=01", bus.state); end
    bus.btn_lap = 1'b1; step(3);
    n_cmp++; if (bus.lap_hold !== 1'b1) begin n_bad++; $display("FAIL lap_set got=%b exp=1", bus.lap_hold); end
    bus.btn_lap = 1'b0;
    bus.counter_tick = 1'b1; step(1); bus.counter_tick = 1'b0;
    n_cmp++; if (bus.cnt_en !== 1'b1) begin n_bad++; $display("FAIL lap_counting got=%b exp=1", bus.cnt_en); end
    step(2);
    bus.btn_lap = 1'b1; step(3);
    n_cmp++; if (bus.lap_hold !== 1'b0) begin n_bad++; $display("FAIL lap_toggle_off got=%b exp=0", bus.lap_hold); end
    bus.btn_lap = 1'b0; step(3);
    bus.btn_lap = 1'b1; step(3);
    n_cmp++; if (bus.lap_hold !== 1'b1) begin n_bad++; $display("FAIL lap_reset got=%b exp=1", bus.lap_hold); end
    bus.btn_lap = 1'b0; step(3);
    bus.btn_clr = 1'b1; step(3);
    n_cmp++; if ({bus.lap_hold, bus.state} !== 3'b000) begin n_bad++;
      $display("FAIL lap_clr got=%b exp=000", {bus.lap_hold, bus.state}); end
    bus.btn_clr = 1'b0; step(3);
  endtask
`endif

  initial begin
    bus.btn_pause = 1'b1; bus.btn_clr = 1'b0; bus.sw_adj = 1'b0; bus.sw_sel = 1'b0;
    bus.counter_tick = 1'b0; bus.adj_tick = 1'b0; bus.blink_tick = 1'b0;
`ifdef STOPWATCH_CTRL_LAP_HOLD_EN
    bus.btn_lap = 1'b0;
`endif
    zero_counts();
    @(negedge clk);
    test_reset();
    test_run_count();
    test_clr_pause_same();
    test_adjust();
    test_adj_clr();
    test_reset_mid();
`ifdef STOPWATCH_CTRL_LAP_HOLD_EN
    test_lap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
